// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Four-requester round-robin arbiter with registered one-hot grant,
//            encoded index and a hold-timeout watchdog that force-releases an
//            owner after MAX_HOLD consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Last counter value an owner may reach before it is forced off.
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

    state_t           state_q,   state_d;
    logic [3:0]       gnt_q,     gnt_d;
    logic [1:0]       idx_q,     idx_d;
    logic [1:0]       last_q,    last_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       w_win_idx;
    logic             w_win_vld;
    logic             w_rel_withdraw;
    logic             w_rel_timeout;
    logic             w_release;

    // Rotating priority search: start just after the last owner, previous owner last.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_win_vld && req[last_q + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win_idx = last_q + 2'(k);
            end
        end
    end

    // Release conditions for the current owner; only meaningful in S_GRANT.
    assign w_rel_withdraw = ~req[idx_q];
    assign w_rel_timeout  = (cnt_q == c_hold_last);
    assign w_release      = (state_q == S_GRANT) &&
                            (done || w_rel_withdraw || w_rel_timeout);

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_win_vld) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << w_win_idx;
                    idx_d   = w_win_idx;
                    last_d  = w_win_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    // A watchdog release is only reported when nothing else released the owner.
                    timeout_d = w_rel_timeout & ~done & ~w_rel_withdraw;
                    if (w_win_vld) begin
                        gnt_d  = 4'b0001 << w_win_idx;
                        idx_d  = w_win_idx;
                        last_d = w_win_idx;
                        cnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = 4'b0000;
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != c_hold_last) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Brief    : Directed checks of rotation, watchdog, withdrawal and reset for
//            rr_arbiter4, followed by a random phase against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;
    localparam int STARVE   = 3 * MAX_HOLD + 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Random-phase model and bookkeeping.
    logic [3:0] m_gnt, nx_gnt, r, prev_gnt;
    int         m_last, m_cnt, m_own, nx_last, nx_cnt, nx_own;
    logic       nx_to, found, grant_new, rd, rw, rt, rel_in;
    int         sh, win, run;
    logic [7:0] dbl;
    logic [3:0] rot;
    int         starve [4];

    always #5 clk = ~clk;

    rr_arbiter4 #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic t);
        chk({tag, ".gnt"},     8'(gnt),       8'(g));
        chk({tag, ".idx"},     8'(gnt_idx),   8'(i));
        chk({tag, ".valid"},   8'(gnt_valid), 8'(v));
        chk({tag, ".timeout"}, 8'(timeout),   8'(t));
    endtask

    task automatic hold(input string tag, input int n, input logic [3:0] g, input logic [1:0] i);
        for (int c = 0; c < n; c++) begin
            tick();
            chk_out(tag, g, i, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotation with done pulsed on every grant.
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        chk_out("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick(); chk_out("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_out("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick(); chk_out("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk_out("rot4", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick(); chk_out("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Sole requester times out after 16 cycles and is re-granted.
        req = 4'b0100;
        tick(); chk_out("solo_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        hold("solo_hold", MAX_HOLD - 1, 4'b0100, 2'd2);
        tick(); chk_out("solo_to", 4'b0100, 2'd2, 1'b1, 1'b1);
        hold("solo_hold2", MAX_HOLD - 1, 4'b0100, 2'd2);
        tick(); chk_out("solo_to2", 4'b0100, 2'd2, 1'b1, 1'b1);
        req = 4'b0000;
        tick(); chk_out("solo_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Two requesters alternate on timeout.
        req = 4'b0101;
        tick(); chk_out("pair_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        hold("pair_hold0", MAX_HOLD - 1, 4'b0001, 2'd0);
        tick(); chk_out("pair_to2", 4'b0100, 2'd2, 1'b1, 1'b1);
        hold("pair_hold2", MAX_HOLD - 1, 4'b0100, 2'd2);
        tick(); chk_out("pair_to0", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        tick(); chk_out("pair_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner withdraws with another requester pending.
        req = 4'b1010;
        tick(); chk_out("wd_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        tick(); chk_out("wd_to3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req  = 4'b0000;
        done = 1'b1;
        tick(); chk_out("wd_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(); chk_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done coinciding with the watchdog limit suppresses the timeout pulse.
        done = 1'b0;
        req  = 4'b0100;
        tick(); chk_out("prio_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        hold("prio_hold", MAX_HOLD - 1, 4'b0100, 2'd2);
        done = 1'b1;
        tick(); chk_out("prio_rel", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick(); chk_out("prio_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a grant restores the pointer.
        req = 4'b0100;
        tick(); chk_out("mid_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(); chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b0110;
        tick(); chk_out("ptr_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(); chk_out("mid_rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1001;
        tick(); chk_out("ptr_rst2", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Random phase against a cycle model plus structural invariants.
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        rst_n    = 1'b1;
        m_gnt    = 4'b0000;
        m_last   = 3;
        m_cnt    = 0;
        m_own    = 0;
        r        = 4'b0000;
        prev_gnt = 4'b0000;
        run      = 0;
        for (int a = 0; a < 4; a++) starve[a] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            req  = r;
            done = ($urandom_range(7) == 0);

            sh    = (m_last + 1) % 4;
            dbl   = {req, req};
            rot   = 4'(dbl >> sh);
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && rot[k]) begin
                    found = 1'b1;
                    win   = (sh + k) % 4;
                end
            end
            nx_gnt    = m_gnt;
            nx_last   = m_last;
            nx_cnt    = m_cnt;
            nx_own    = m_own;
            nx_to     = 1'b0;
            grant_new = 1'b0;
            if (m_gnt == 4'b0000) begin
                grant_new = found;
            end else begin
                rd = done;
                rw = !req[m_own];
                rt = (m_cnt == MAX_HOLD - 1);
                if (rd || rw || rt) begin
                    nx_to = rt && !rd && !rw;
                    if (found) grant_new = 1'b1;
                    else begin
                        nx_gnt = 4'b0000;
                        nx_cnt = 0;
                        nx_own = 0;
                    end
                end else begin
                    nx_cnt = m_cnt + 1;
                end
            end
            if (grant_new) begin
                nx_gnt  = 4'b0001 << win;
                nx_last = win;
                nx_own  = win;
                nx_cnt  = 0;
            end
            rel_in = (prev_gnt != 4'b0000) && (done || ((req & prev_gnt) == 4'b0000));

            tick();

            chk_out("rnd", nx_gnt, 2'(nx_own), |nx_gnt, nx_to);
            chk("rnd.onehot", 8'($countones(gnt) <= 1), 8'd1);
            chk("rnd.enc", 8'(gnt_idx), 8'({gnt[2] | gnt[3], gnt[1] | gnt[3]}));
            if (gnt != 4'b0000 && gnt == prev_gnt && !rel_in && !timeout) run++;
            else run = (gnt != 4'b0000) ? 1 : 0;
            chk("rnd.hold", 8'(run <= MAX_HOLD), 8'd1);
            for (int a = 0; a < 4; a++) begin
                if (gnt[a] || !req[a]) starve[a] = 0;
                else starve[a]++;
                chk("rnd.starve", 8'(starve[a] <= STARVE), 8'd1);
            end

            m_gnt    = nx_gnt;
            m_last   = nx_last;
            m_cnt    = nx_cnt;
            m_own    = nx_own;
            prev_gnt = gnt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
